fft_spectrum_buf: RTL and testbench
===================================

Name: fft_spectrum_buf

Overview:
- Sits between the FFT modulus output and the LCD drawing logic.
- Captures one complete FFT frame (sop..eop) of magnitude samples and keeps the lowest BAR_N bins.
- Scales each kept bin to a saturated bar height.
- Holds heights in a ping-pong buffer that swaps only on a display frame boundary, so the LCD always reads a whole, tear-free spectrum.

Parameters:
FFT_N, 128, bins per FFT frame (sop to eop inclusive)
BAR_N, 64, bins kept and displayed (bins 0..BAR_N-1), BAR_N <= FFT_N
DATA_W, 16, FFT magnitude width
SHIFT, 4, right shift applied to magnitude before saturation
H_MAX, 272, maximum bar height in pixels
H_W, 9, bar height width, 2^H_W > H_MAX

Ports:
clk  input  1  system clock (50 MHz domain shared with FFT output and LCD logic)
rst_n  input  1  asynchronous active-low reset
fft_data  input  DATA_W  FFT magnitude sample
fft_sop  input  1  first bin of frame, qualified by fft_valid
fft_eop  input  1  last bin of frame, qualified by fft_valid
fft_valid  input  1  sample strobe; may have arbitrary gaps
frame_sync  input  1  one-cycle pulse at LCD vertical blanking start
rd_addr  input  $clog2(BAR_N)+1  bar index requested by LCD
rd_data  output  H_W  bar height for rd_addr
spec_ready  output  1  one-cycle pulse when a new spectrum becomes readable
frame_err  output  1  one-cycle pulse on malformed frame
frame_drop  output  1  one-cycle pulse when a frame is discarded because the buffer is full

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: rd_data=0, spec_ready=0, frame_err=0, frame_drop=0, state=IDLE, bin counter=0, write bank=0, have_data=0. Memory contents are not reset; reads return 0 while have_data=0.
- Height computation: t = fft_data >> SHIFT; h = (t > H_MAX) ? H_MAX : t[H_W-1:0]. Written to the write bank at the address equal to the bin index, only for bin < BAR_N.
- Capture FSM:
  - IDLE:
    - valid&sop → write bin 0, cnt=1, go CAPT.
    - valid without sop → ignored.
    - valid&sop&eop with FFT_N>1 → frame_err, stay IDLE.
  - CAPT, on valid:
    - sop → restart: frame_err pulse, write bin 0, cnt=1, stay CAPT.
    - eop with cnt==FFT_N-1 → write bin, go DONE.
    - eop with cnt!=FFT_N-1 → frame_err, go IDLE.
    - no eop with cnt==FFT_N-1 → frame_err, go IDLE.
    - otherwise → write bin cnt, cnt++.
  - DONE:
    - all fft input ignored.
    - valid&sop → frame_drop pulse.
    - frame_sync → toggle write bank, set have_data=1, spec_ready pulse the next cycle, go IDLE.
    - A frame_sync in the same cycle as the eop that enters DONE is not taken; the next frame_sync swaps.
- Simultaneous events:
  - frame_sync with valid&sop in DONE → swap happens, that sop is dropped (frame_drop=1), FSM goes IDLE.
  - A frame_sync outside DONE has no effect.
- Read port:
  - Reads the bank opposite the write bank.
  - rd_data is registered, 1-cycle latency from rd_addr.
  - rd_addr >= BAR_N or have_data=0 → rd_data=0 next cycle.
  - The read bank never changes except in the swap cycle; the read after the swap cycle uses the new bank.
- Reset mid-capture: immediately returns to IDLE; partial frame discarded; have_data cleared.
- Memory: two banks of BAR_N x H_W, inferable as a simple dual-port RAM (one write, one read).

Test Plan:
- Reset then rd_addr sweep 0..63 → rd_data=0 for all; no pulses.
- Clean frame: bins k=0..127 with fft_data=k*16, sop at k=0, eop at k=127, one idle cycle between valids, then frame_sync → spec_ready pulse 1 cycle after sync; rd_addr=5 → rd_data=5; rd_addr=63 → 63; rd_addr=64 → 0.
- Saturation: frame with all bins 0xFFFF → after swap every bar reads 272; frame with 4352 (t=272) → 272; 4368 → 272; 4336 → 271.
- Short frame: eop at bin 99 → frame_err pulse on that cycle, FSM IDLE, following frame_sync gives no spec_ready, reads still show the previous spectrum.
- Overrun: two complete frames (values A then B) before any frame_sync → frame_drop pulse at the second sop; after sync reads show A; a third frame then sync shows its values.
- Async reset asserted at bin 40 of a frame, released, new clean frame plus sync → reads show only the new frame; before that sync all reads are 0.

Source files
------------

// File: rtl/fft_spectrum_buf.sv
// Captures one FFT magnitude frame, scales the lowest BAR_N bins to saturated bar
// heights, and serves them to the LCD from a ping-pong buffer swapped at frame_sync.
module fft_spectrum_buf #(
    parameter int FFT_N  = 128,
    parameter int BAR_N  = 64,
    parameter int DATA_W = 16,
    parameter int SHIFT  = 4,
    parameter int H_MAX  = 272,
    parameter int H_W    = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          fft_data,
    input  logic                       fft_sop,
    input  logic                       fft_eop,
    input  logic                       fft_valid,
    input  logic                       frame_sync,
    input  logic [$clog2(BAR_N):0]     rd_addr,
    output logic [H_W-1:0]             rd_data,
    output logic                       spec_ready,
    output logic                       frame_err,
    output logic                       frame_drop
);
    localparam int AW = (BAR_N > 1) ? $clog2(BAR_N) : 1;
    localparam int CW = (FFT_N > 1) ? $clog2(FFT_N) : 1;
    localparam logic [CW:0]      BAR_LIM = (CW+1)'(BAR_N);
    localparam logic [CW-1:0]    LAST    = CW'(FFT_N - 1);
    localparam logic [DATA_W-1:0] HMAX_D = DATA_W'(H_MAX);

    typedef enum logic [1:0] {IDLE, CAPT, DONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n, wbin;
    logic             wbank, have_data;
    logic             bin_we, swap, err_n, drop_n;
    logic [DATA_W-1:0] t;
    logic [H_W-1:0]   h;

    logic [H_W-1:0] mem [0:2*BAR_N-1];

    assign t = fft_data >> SHIFT;
    assign h = (t > HMAX_D) ? H_W'(H_MAX) : t[H_W-1:0];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wbin    = cnt;
        bin_we  = 1'b0;
        swap    = 1'b0;
        err_n   = 1'b0;
        drop_n  = 1'b0;
        case (state)
            IDLE: begin
                if (fft_valid && fft_sop) begin
                    if (fft_eop && FFT_N > 1) begin
                        err_n = 1'b1;
                    end else begin
                        bin_we  = 1'b1;
                        wbin    = '0;
                        cnt_n   = CW'(1);
                        state_n = (FFT_N > 1) ? CAPT : DONE;
                    end
                end
            end
            CAPT: begin
                if (fft_valid) begin
                    if (fft_sop) begin
                        // a new sop mid-frame restarts capture from bin 0
                        err_n  = 1'b1;
                        bin_we = 1'b1;
                        wbin   = '0;
                        cnt_n  = CW'(1);
                    end else if (fft_eop) begin
                        cnt_n = '0;
                        if (cnt == LAST) begin
                            bin_we  = 1'b1;
                            state_n = DONE;
                        end else begin
                            err_n   = 1'b1;
                            state_n = IDLE;
                        end
                    end else if (cnt == LAST) begin
                        err_n   = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        bin_we = 1'b1;
                        cnt_n  = cnt + CW'(1);
                    end
                end
            end
            DONE: begin
                drop_n = fft_valid && fft_sop;
                if (frame_sync) begin
                    swap    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            wbank      <= 1'b0;
            have_data  <= 1'b0;
            spec_ready <= 1'b0;
            frame_err  <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            spec_ready <= swap;
            frame_err  <= err_n;
            frame_drop <= drop_n;
            if (swap) begin
                wbank     <= ~wbank;
                have_data <= 1'b1;
            end
        end
    end

    // bins at or above BAR_N are counted but never stored
    always_ff @(posedge clk) begin
        if (bin_we && ({1'b0, wbin} < BAR_LIM))
            mem[{wbank, wbin[AW-1:0]}] <= h;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else if (have_data && (rd_addr < (AW+1)'(BAR_N)))
            rd_data <= mem[{~wbank, rd_addr[AW-1:0]}];
        else
            rd_data <= '0;
    end
endmodule

// File: tb/tb_fft_spectrum_buf.sv
// Self-checking bench for fft_spectrum_buf: frame capture, saturation, error,
// overrun and reset scenarios with a scoreboard on the read port.
module tb_fft_spectrum_buf;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] fft_data = '0;
    logic        fft_sop = 1'b0, fft_eop = 1'b0, fft_valid = 1'b0, frame_sync = 1'b0;
    logic [6:0]  rd_addr = '0;
    logic [8:0]  rd_data;
    logic        spec_ready, frame_err, frame_drop;

    fft_spectrum_buf dut (
        .clk(clk), .rst_n(rst_n), .fft_data(fft_data), .fft_sop(fft_sop),
        .fft_eop(fft_eop), .fft_valid(fft_valid), .frame_sync(frame_sync),
        .rd_addr(rd_addr), .rd_data(rd_data), .spec_ready(spec_ready),
        .frame_err(frame_err), .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          exp_h;
    } vec_t;

    int n_cmp = 0, n_bad = 0;
    int err_cnt = 0, drop_cnt = 0, rdy_cnt = 0;
    logic [15:0] fd [128];
    int shown [64];
    int exp_q [$];
    logic last_err, first_drop;

    always @(negedge clk) begin
        if (frame_err)  err_cnt++;
        if (frame_drop) drop_cnt++;
        if (spec_ready) rdy_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    function automatic int hgt(input logic [15:0] d);
        int t;
        t = int'(d) / 16;
        return (t > 272) ? 272 : t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic rd(input int addr, input int exp, input string name);
        int e;
        @(negedge clk);
        rd_addr = 7'(addr);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        chk(name, int'(rd_data), e);
    endtask

    task automatic sweep_model(input string name);
        for (int a = 0; a < 64; a++) rd(a, shown[a], name);
        rd(64, 0, {name, "_oob"});
    endtask

    // bins 0..n-1 with an idle cycle after each; eop on the last beat if asked
    task automatic send_beats(input int n, input bit do_eop);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            fft_valid = 1'b1;
            fft_data  = fd[k];
            fft_sop   = (k == 0);
            fft_eop   = do_eop && (k == n - 1);
            @(posedge clk); #1;
            if (k == 0)     first_drop = frame_drop;
            if (k == n - 1) last_err   = frame_err;
            @(negedge clk);
            fft_valid = 1'b0; fft_sop = 1'b0; fft_eop = 1'b0;
        end
    endtask

    task automatic sync(input int exp_rdy, input string name);
        @(negedge clk);
        frame_sync = 1'b1;
        @(posedge clk); #1;
        chk(name, int'(spec_ready), exp_rdy);
        @(negedge clk);
        frame_sync = 1'b0;
        @(posedge clk); #1;
        chk({name, "_one_cycle"}, int'(spec_ready), 0);
    endtask

    task automatic load_shown();
        for (int a = 0; a < 64; a++) shown[a] = hgt(fd[a]);
    endtask

    vec_t vt [8];

    initial begin
        vt[0] = '{16'hFFFF, 272};
        vt[1] = '{16'd4352, 272};
        vt[2] = '{16'd4368, 272};
        vt[3] = '{16'd4336, 271};
        vt[4] = '{16'd0,    0};
        vt[5] = '{16'd15,   0};
        vt[6] = '{16'd16,   1};
        vt[7] = '{16'd4351, 271};
        for (int a = 0; a < 64; a++) shown[a] = 0;

        // reset state
        #12;
        chk("reset_rd_data", int'(rd_data), 0);
        chk("reset_pulses", int'({spec_ready, frame_err, frame_drop}), 0);
        @(negedge clk); rst_n = 1'b1;
        sweep_model("reset_sweep");
        chk("reset_no_pulses", err_cnt + drop_cnt + rdy_cnt, 0);

        // clean frame
        for (int k = 0; k < 128; k++) fd[k] = 16'(k * 16);
        send_beats(128, 1'b1);
        chk("clean_no_err", err_cnt, 0);
        sync(1, "clean_ready");
        load_shown();
        rd(5, 5, "clean_rd5");
        rd(63, 63, "clean_rd63");
        rd(64, 0, "clean_rd64");
        sweep_model("clean_sweep");

        // all-max frame
        for (int k = 0; k < 128; k++) fd[k] = 16'hFFFF;
        send_beats(128, 1'b1);
        sync(1, "sat_ready");
        load_shown();
        sweep_model("sat_all");

        // table-driven height vectors
        for (int k = 0; k < 128; k++) fd[k] = vt[k % 8].data;
        send_beats(128, 1'b1);
        sync(1, "tbl_ready");
        for (int a = 0; a < 64; a++) begin
            rd(a, vt[a % 8].exp_h, "tbl_height");
            shown[a] = vt[a % 8].exp_h;
        end

        // short frame: eop at bin 99
        for (int k = 0; k < 128; k++) fd[k] = 16'(k * 8);
        send_beats(100, 1'b1);
        chk("short_err_pulse", int'(last_err), 1);
        sync(0, "short_no_ready");
        sweep_model("short_keeps_prev");

        // overrun: A then B before sync
        for (int k = 0; k < 128; k++) fd[k] = 16'(k * 32);
        send_beats(128, 1'b1);
        load_shown();
        for (int k = 0; k < 128; k++) fd[k] = 16'((127 - k) * 16);
        send_beats(128, 1'b1);
        chk("overrun_drop_pulse", int'(first_drop), 1);
        sync(1, "overrun_ready");
        sweep_model("overrun_shows_A");
        for (int k = 0; k < 128; k++) fd[k] = 16'(k * 48);
        send_beats(128, 1'b1);
        sync(1, "third_ready");
        load_shown();
        sweep_model("third_frame");

        // async reset mid-capture at bin 40
        for (int k = 0; k < 128; k++) fd[k] = 16'(k * 24);
        send_beats(40, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_rd_data", int'(rd_data), 0);
        @(negedge clk); rst_n = 1'b1;
        for (int a = 0; a < 64; a++) shown[a] = 0;
        sweep_model("post_reset_zero");
        for (int k = 0; k < 128; k++) fd[k] = 16'(k * 40);
        send_beats(128, 1'b1);
        rd(10, 0, "pre_sync_zero");
        rd(63, 0, "pre_sync_zero63");
        sync(1, "post_reset_ready");
        load_shown();
        sweep_model("post_reset_frame");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
